// File: rtl/axis_chirp_window_pkg.sv
// Shared constants and the round/saturate helper for the chirp window datapath.
package axis_chirp_window_pkg;

  localparam int SAMPLE_W       = 16;
  localparam int PROD_W         = 33;
  localparam int COEF_FRAC_BITS = 15;

  localparam logic [15:0] COEF_UNITY = 16'h8000;

  localparam logic signed [PROD_W-1:0] ROUND_CONST = 33'sd16384;
  localparam logic signed [PROD_W-1:0] SAT_MAX     = 33'sd32767;
  localparam logic signed [PROD_W-1:0] SAT_MIN     = -33'sd32768;

  typedef struct packed {
    logic [SAMPLE_W-1:0] value;
    logic                sat;
  } rs_result_t;

  // Round half up in Q1.15, then clamp to the signed 16-bit range.
  function automatic rs_result_t round_sat(input logic signed [PROD_W-1:0] prod);
    logic signed [PROD_W-1:0] scaled;
    rs_result_t               res;
    scaled  = (prod + ROUND_CONST) >>> COEF_FRAC_BITS;
    res.sat = 1'b1;
    if (scaled > SAT_MAX) begin
      res.value = SAT_MAX[SAMPLE_W-1:0];
    end else if (scaled < SAT_MIN) begin
      res.value = SAT_MIN[SAMPLE_W-1:0];
    end else begin
      res.value = scaled[SAMPLE_W-1:0];
      res.sat   = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/axis_chirp_window_coef_ram.sv
// Window coefficient store: simple dual-port, registered read-first output.
module chirp_window_coef_ram
  import axis_chirp_window_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  aclk,
  input  logic                  wen,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ren,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  // Contents are stored XOR unity so an all-zero BRAM at configuration reads as 1.0.
  localparam logic [DATA_WIDTH-1:0] UNITY_ENC = DATA_WIDTH'(COEF_UNITY);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // NOTE: the array and its read register take no reset; a reset port would stop BRAM inference.
  always_ff @(posedge aclk) begin
    if (wen) begin
      mem_q[waddr] <= wdata ^ UNITY_ENC;
    end
    if (ren) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q ^ UNITY_ENC;

endmodule

// File: rtl/axis_chirp_window.sv
// Applies a per-index Q1.15 window to framed I/Q samples ahead of the FFT core.
module axis_chirp_window
  import axis_chirp_window_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int INDEX_WIDTH      = 16,
  parameter int COEF_WIDTH       = 16,
  parameter int ADDR_WIDTH       = 12
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        cfg_wen,
  input  logic [ADDR_WIDTH-1:0]       cfg_waddr,
  input  logic [COEF_WIDTH-1:0]       cfg_wdata,
  input  logic                        cfg_bypass,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [INDEX_WIDTH-1:0]      s_axis_tuser,
  input  logic                        s_axis_tvalid,
  input  logic                        s_axis_tlast,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [INDEX_WIDTH-1:0]      m_axis_tuser,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready,
  output logic                        err_sat,
  output logic [31:0]                 frame_count
);

  logic                        adv;
  logic [COEF_WIDTH-1:0]       coef_rd;
  logic [COEF_WIDTH-1:0]       coef;
  logic signed [PROD_W-1:0]    samp_i, samp_q, coef_ext;
  rs_result_t                  res_i, res_q;

  logic                        s0_valid_q, s0_valid_d;
  logic [AXIS_TDATA_WIDTH-1:0] s0_data_q, s0_data_d;
  logic [INDEX_WIDTH-1:0]      s0_user_q, s0_user_d;
  logic                        s0_last_q, s0_last_d;
  logic                        s0_bypass_q, s0_bypass_d;

  logic                        s1_valid_q, s1_valid_d;
  logic signed [PROD_W-1:0]    s1_prod_i_q, s1_prod_i_d;
  logic signed [PROD_W-1:0]    s1_prod_q_q, s1_prod_q_d;
  logic [INDEX_WIDTH-1:0]      s1_user_q, s1_user_d;
  logic                        s1_last_q, s1_last_d;

  logic                        m_valid_q, m_valid_d;
  logic [AXIS_TDATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [INDEX_WIDTH-1:0]      m_user_q, m_user_d;
  logic                        m_last_q, m_last_d;
  logic                        err_sat_q, err_sat_d;
  logic [31:0]                 frame_count_q, frame_count_d;

  // The RAM read register is S0's coefficient slot, so it only reloads on advance.
  chirp_window_coef_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (COEF_WIDTH)
  ) u_coef_ram (
    .aclk  (aclk),
    .wen   (cfg_wen),
    .waddr (cfg_waddr),
    .wdata (cfg_wdata),
    .ren   (adv),
    .raddr (s_axis_tuser[ADDR_WIDTH-1:0]),
    .rdata (coef_rd)
  );

  // NOTE: every signal assigned here gets a default first so no path can infer a latch.
  always_comb begin
    adv      = ~m_valid_q | m_axis_tready;
    coef     = s0_bypass_q ? COEF_WIDTH'(COEF_UNITY) : coef_rd;
    samp_i   = PROD_W'($signed(s0_data_q[SAMPLE_W-1:0]));
    samp_q   = PROD_W'($signed(s0_data_q[2*SAMPLE_W-1:SAMPLE_W]));
    coef_ext = $signed(PROD_W'(coef));
    res_i    = round_sat(s1_prod_i_q);
    res_q    = round_sat(s1_prod_q_q);

    s0_valid_d    = s0_valid_q;
    s0_data_d     = s0_data_q;
    s0_user_d     = s0_user_q;
    s0_last_d     = s0_last_q;
    s0_bypass_d   = s0_bypass_q;
    s1_valid_d    = s1_valid_q;
    s1_prod_i_d   = s1_prod_i_q;
    s1_prod_q_d   = s1_prod_q_q;
    s1_user_d     = s1_user_q;
    s1_last_d     = s1_last_q;
    m_valid_d     = m_valid_q;
    m_data_d      = m_data_q;
    m_user_d      = m_user_q;
    m_last_d      = m_last_q;
    err_sat_d     = err_sat_q;
    frame_count_d = frame_count_q;

    if (adv) begin
      s0_valid_d = s_axis_tvalid;
      s1_valid_d = s0_valid_q;
      m_valid_d  = s1_valid_q;
      if (s_axis_tvalid) begin
        s0_data_d   = s_axis_tdata;
        s0_user_d   = s_axis_tuser;
        s0_last_d   = s_axis_tlast;
        s0_bypass_d = cfg_bypass;
      end
      if (s0_valid_q) begin
        s1_prod_i_d = samp_i * coef_ext;
        s1_prod_q_d = samp_q * coef_ext;
        s1_user_d   = s0_user_q;
        s1_last_d   = s0_last_q;
      end
      if (s1_valid_q) begin
        m_data_d = AXIS_TDATA_WIDTH'({res_q.value, res_i.value});
        m_user_d = s1_user_q;
        m_last_d = s1_last_q;
        if (res_i.sat || res_q.sat) begin
          err_sat_d = 1'b1;
        end
      end
    end

    if (m_valid_q && m_axis_tready && m_last_q) begin
      frame_count_d = frame_count_q + 32'd1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      s0_valid_q    <= 1'b0;
      s1_valid_q    <= 1'b0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      m_user_q      <= '0;
      m_last_q      <= 1'b0;
      err_sat_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      s0_valid_q    <= s0_valid_d;
      s1_valid_q    <= s1_valid_d;
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
      m_user_q      <= m_user_d;
      m_last_q      <= m_last_d;
      err_sat_q     <= err_sat_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Internal payload is qualified by the stage valids, so it needs no reset.
  always_ff @(posedge aclk) begin
    s0_data_q   <= s0_data_d;
    s0_user_q   <= s0_user_d;
    s0_last_q   <= s0_last_d;
    s0_bypass_q <= s0_bypass_d;
    s1_prod_i_q <= s1_prod_i_d;
    s1_prod_q_q <= s1_prod_q_d;
    s1_user_q   <= s1_user_d;
    s1_last_q   <= s1_last_d;
  end

  assign s_axis_tready = adv | ~aresetn;
  assign m_axis_tdata  = m_data_q;
  assign m_axis_tuser  = m_user_q;
  assign m_axis_tvalid = m_valid_q;
  assign m_axis_tlast  = m_last_q;
  assign err_sat       = err_sat_q;
  assign frame_count   = frame_count_q;

endmodule

// File: doc/axis_chirp_window.md
AXIS_CHIRP_WINDOW -- requirements
Module: axis_chirp_window

Interface
REQ-001 The block SHALL have parameter AXIS_TDATA_WIDTH, default 32, meaning the sample width: I in [15:0], Q in [31:16], both signed.
REQ-002 The block SHALL have parameter INDEX_WIDTH, default 16, meaning the tuser width carrying the in-frame sample index.
REQ-003 The block SHALL have parameter COEF_WIDTH, default 16, meaning the unsigned Q1.15 window coefficient width, where 0x8000 = 1.0.
REQ-004 The block SHALL have parameter ADDR_WIDTH, default 12, meaning log2 of the coefficient RAM depth (4096).
REQ-005 The block SHALL have port aclk, input, 1 bit: clock; all logic is on its rising edge.
REQ-006 The block SHALL have port aresetn, input, 1 bit: reset, synchronous, active-low.
REQ-007 The block SHALL have port cfg_wen, input, 1 bit: coefficient write strobe.
REQ-008 The block SHALL have port cfg_waddr, input, ADDR_WIDTH bits: coefficient write address.
REQ-009 The block SHALL have port cfg_wdata, input, COEF_WIDTH bits: coefficient write data.
REQ-010 The block SHALL have port cfg_bypass, input, 1 bit: when 1, the coefficient is forced to unity.
REQ-011 The block SHALL have port s_axis_tdata / tuser / tvalid / tlast, inputs, AXIS_TDATA_WIDTH / INDEX_WIDTH / 1 / 1 bits: framed stream from the chirp framer.
REQ-012 The block SHALL have port s_axis_tready, output, 1 bit: upstream ready.
REQ-013 The block SHALL have port m_axis_tdata / tuser / tvalid / tlast, outputs, AXIS_TDATA_WIDTH / INDEX_WIDTH / 1 / 1 bits: windowed stream to the FFT core.
REQ-014 The block SHALL have port m_axis_tready, input, 1 bit: downstream ready.
REQ-015 The block SHALL have port err_sat, output, 1 bit: sticky saturation flag.
REQ-016 The block SHALL have port frame_count, output, 32 bits: number of output beats accepted with tlast.

Function
REQ-017 The block SHALL be a 3-stage pipeline: S0 coefficient read, S1 multiply, S2 round/saturate into the output register; each stage has its own valid bit.
REQ-018 The pipeline SHALL advance when (~m_axis_tvalid | m_axis_tready); s_axis_tready SHALL equal this advance term.
REQ-019 A beat accepted at cycle N with no stall SHALL appear on m_axis at cycle N+3.
REQ-020 Stalls SHALL hold all stage contents unchanged, with no loss or duplication of beats.
REQ-021 The coefficient RAM address SHALL be s_axis_tuser[ADDR_WIDTH-1:0]; higher tuser bits are ignored for addressing.
REQ-022 tuser and tlast SHALL travel with their sample unchanged through all stages.
REQ-023 Per component: product = signed sample × zero-extended coefficient, 33-bit signed.
REQ-024 Per component: result = (product + 2^14) >>> 15 (arithmetic shift), saturated to [-32768, 32767].
REQ-025 Any saturation of I or Q on an S2 advance SHALL set err_sat; err_sat remains 1 until reset.
REQ-026 When cfg_bypass = 1, the coefficient SHALL be 0x8000 and the output SHALL equal the input bit-exactly; cfg_bypass is sampled at S0.
REQ-027 A coefficient write SHALL be visible to reads from the next cycle.
REQ-028 A read and write to the same address in the same cycle SHALL return the old data (read-first).
REQ-029 cfg writes SHALL be accepted regardless of stream state or stalls.
REQ-030 frame_count SHALL increment on m_axis_tvalid & m_axis_tready & m_axis_tlast, and wrap from 2^32-1 to 0.

Reset
REQ-031 While aresetn = 0: all stage valids = 0, m_axis_tvalid = 0, m_axis_tdata/tuser/tlast = 0, err_sat = 0, frame_count = 0.
REQ-032 s_axis_tready SHALL be 1 during reset, because the output is invalid; beats presented during reset are discarded.
REQ-033 Reset mid-frame SHALL flush all in-flight beats with no partial output after release.
REQ-034 RAM contents SHALL NOT be affected by reset; they are initialised to 0x8000 at configuration.

Structure
REQ-035 A shared package SHALL hold COEF_UNITY = 0x8000, COEF_FRAC_BITS = 15, the round constant 2^14, and the saturation limits.
REQ-036 Coefficient storage SHALL be one sub-module, chirp_window_coef_ram: simple dual-port, 1-cycle registered read, read-first, inferable as BRAM.

Verification
REQ-037 Bypass test: bypass = 1, frame of 16 beats I = Q = index − 8 -> identical data out, tlast on index 15, latency 3, frame_count = 1.
REQ-038 Scaling test: coef[5] = 0x4000, input I = 1001, Q = −1001 at tuser 5 -> I = 501, Q = −500 (round half up), err_sat = 0.
REQ-039 Saturation test: coef[0] = 0xFFFF, I = 32767, Q = −32768 -> I = 32767, Q = −32768, err_sat = 1 and held.
REQ-040 Backpressure test: random m_axis_tready at 30 % duty over 256 beats -> output sequence equals the model, no drop or duplicate, tuser/tlast aligned.
REQ-041 Collision test: write coef[7] = 0x2000 in the same cycle a tuser = 7 beat enters S0 -> old coefficient used; the next tuser = 7 beat uses 0x2000.
REQ-042 Reset test: assert aresetn = 0 for 1 cycle with 2 beats in flight -> m_axis_tvalid = 0 the next cycle, those beats never emerge, counters = 0.
